// File: rtl/iir_notch_biquad_if.sv
// Stream and coefficient bundle between the 2/3 decimator side and the notch biquad.
// The master drives samples, coefficients and controls; the slave is the filter.
interface iir_notch_biquad_if #(
    parameter int DATA_WIDTH = 16
);
    logic                         EN;
    logic                         bypass;
    logic signed [DATA_WIDTH-1:0] x_in;
    logic                         valid_in;
    logic signed [DATA_WIDTH-1:0] b0;
    logic signed [DATA_WIDTH-1:0] b1;
    logic signed [DATA_WIDTH-1:0] b2;
    logic signed [DATA_WIDTH-1:0] a1;
    logic signed [DATA_WIDTH-1:0] a2;
    logic                         ready;
    logic signed [DATA_WIDTH-1:0] y_out;
    logic                         valid_out;
    logic                         overrun;

    modport master (
        output EN, bypass, x_in, valid_in, b0, b1, b2, a1, a2,
        input  ready, y_out, valid_out, overrun
    );

    modport slave (
        input  EN, bypass, x_in, valid_in, b0, b1, b2, a1, a2,
        output ready, y_out, valid_out, overrun
    );
endinterface

// File: rtl/iir_notch_biquad.sv
// Direct-form-I biquad with two time-shared multipliers over a 3-cycle schedule,
// saturated output and a sticky overrun flag for samples arriving while busy.
module iir_notch_biquad #(
    parameter int DATA_WIDTH = 16,
    parameter int FRAC_WIDTH = 14,
    parameter int ACC_WIDTH  = 40
) (
    input  logic                      CLK,
    input  logic                      RST,
    iir_notch_biquad_if.slave         bus
);
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        S1   = 2'd1,
        S2   = 2'd2
    } state_t;

    localparam int PROD_WIDTH = 2 * DATA_WIDTH;
    localparam logic signed [ACC_WIDTH-1:0] SAT_MAX =
        ACC_WIDTH'((64'sd1 <<< (DATA_WIDTH - 1)) - 64'sd1);
    localparam logic signed [ACC_WIDTH-1:0] SAT_MIN = -SAT_MAX - ACC_WIDTH'(1);

    state_t                       state_q, state_d;
    logic signed [ACC_WIDTH-1:0]  acc_q, acc_d;
    logic signed [DATA_WIDTH-1:0] x1_q, x1_d, x2_q, x2_d;
    logic signed [DATA_WIDTH-1:0] y1_q, y1_d, y2_q, y2_d;
    logic signed [DATA_WIDTH-1:0] xs_q, xs_d;
    logic signed [DATA_WIDTH-1:0] b2s_q, b2s_d, a1s_q, a1s_d, a2s_q, a2s_d;
    logic signed [DATA_WIDTH-1:0] y_out_q, y_out_d;
    logic                         valid_out_q, valid_out_d;
    logic                         overrun_q, overrun_d;

    logic signed [DATA_WIDTH-1:0] m0_a, m0_b, m1_a, m1_b;
    logic signed [PROD_WIDTH-1:0] prod0, prod1;
    logic signed [ACC_WIDTH-1:0]  prod0_ext, prod1_ext;
    logic signed [ACC_WIDTH-1:0]  result, shifted;
    logic signed [DATA_WIDTH-1:0] y_sat;

    always_comb begin
        // NOTE: every variable gets a default before the case so no path leaves it unassigned (no latch).
        m0_a = '0;
        m0_b = '0;
        m1_a = '0;
        m1_b = '0;
        unique case (state_q)
            IDLE: begin
                m0_a = bus.b0;  m0_b = bus.x_in;
                m1_a = bus.b1;  m1_b = x1_q;
            end
            S1: begin
                m0_a = b2s_q;   m0_b = x2_q;
                m1_a = a1s_q;   m1_b = y1_q;
            end
            S2: begin
                m1_a = a2s_q;   m1_b = y2_q;
            end
            default: ;
        endcase

        prod0     = m0_a * m0_b;
        prod1     = m1_a * m1_b;
        prod0_ext = prod0;
        prod1_ext = prod1;

        // Final accumulate of the S2 step, then Q2.14 -> integer with floor rounding.
        result  = acc_q - prod1_ext;
        shifted = result >>> FRAC_WIDTH;
        if (shifted > SAT_MAX) begin
            y_sat = SAT_MAX[DATA_WIDTH-1:0];
        end else if (shifted < SAT_MIN) begin
            y_sat = SAT_MIN[DATA_WIDTH-1:0];
        end else begin
            y_sat = shifted[DATA_WIDTH-1:0];
        end
    end

    always_comb begin
        state_d     = state_q;
        acc_d       = acc_q;
        x1_d        = x1_q;
        x2_d        = x2_q;
        y1_d        = y1_q;
        y2_d        = y2_q;
        xs_d        = xs_q;
        b2s_d       = b2s_q;
        a1s_d       = a1s_q;
        a2s_d       = a2s_q;
        y_out_d     = y_out_q;
        valid_out_d = 1'b0;
        overrun_d   = overrun_q;

        if (bus.EN) begin
            unique case (state_q)
                IDLE: begin
                    if (bus.valid_in && bus.bypass) begin
                        y_out_d     = bus.x_in;
                        valid_out_d = 1'b1;
                        x1_d        = '0;
                        x2_d        = '0;
                        y1_d        = '0;
                        y2_d        = '0;
                    end else if (bus.valid_in) begin
                        acc_d   = prod0_ext + prod1_ext;
                        xs_d    = bus.x_in;
                        b2s_d   = bus.b2;
                        a1s_d   = bus.a1;
                        a2s_d   = bus.a2;
                        state_d = S1;
                    end
                end
                S1: begin
                    if (bus.valid_in) overrun_d = 1'b1;
                    acc_d   = acc_q + prod0_ext - prod1_ext;
                    state_d = S2;
                end
                S2: begin
                    if (bus.valid_in) overrun_d = 1'b1;
                    acc_d       = result;
                    y_out_d     = y_sat;
                    valid_out_d = 1'b1;
                    x2_d        = x1_q;
                    x1_d        = xs_q;
                    y2_d        = y1_q;
                    y1_d        = y_sat;
                    state_d     = IDLE;
                end
                default: state_d = IDLE;
            endcase
        end
    end

    // NOTE: state registers use non-blocking assignments so all flops update together at the edge.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q     <= IDLE;
            acc_q       <= '0;
            x1_q        <= '0;
            x2_q        <= '0;
            y1_q        <= '0;
            y2_q        <= '0;
            xs_q        <= '0;
            b2s_q       <= '0;
            a1s_q       <= '0;
            a2s_q       <= '0;
            y_out_q     <= '0;
            valid_out_q <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            acc_q       <= acc_d;
            x1_q        <= x1_d;
            x2_q        <= x2_d;
            y1_q        <= y1_d;
            y2_q        <= y2_d;
            xs_q        <= xs_d;
            b2s_q       <= b2s_d;
            a1s_q       <= a1s_d;
            a2s_q       <= a2s_d;
            y_out_q     <= y_out_d;
            valid_out_q <= valid_out_d;
            overrun_q   <= overrun_d;
        end
    end

    assign bus.ready     = (state_q == IDLE);
    assign bus.y_out     = y_out_q;
    assign bus.valid_out = valid_out_q;
    assign bus.overrun   = overrun_q;
endmodule
